// File: rtl/ibex_l2_regfile_responder_pkg.sv
// Shared types and helpers for the L2 register backing store and its L1 initiator.
package ibex_l2_rf_pkg;

  localparam int unsigned TagWidth = 5;
  localparam int unsigned L1_LO    = 8;
  localparam int unsigned L1_HI    = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // x8..x15 live in L1, so the upper registers are packed down by four tags.
  function automatic logic [TagWidth-1:0] addr_to_tag(input logic [TagWidth-1:0] addr);
    return (addr >= 5'd16) ? addr - 5'd4 : addr;
  endfunction

endpackage

// File: rtl/ibex_l2_regfile_responder_if.sv
// Request/response handshake between the L1 register file and the L2 responder.
interface ibex_l2_regfile_responder_if
  import ibex_l2_rf_pkg::*;
#(
  parameter int unsigned DataWidth = 32
);

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [TagWidth-1:0]  req_tag_i;
  logic [DataWidth-1:0] req_wdata_i;
  logic                 rsp_valid_o;
  logic [DataWidth-1:0] rsp_rdata_o;
  logic                 rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_tag_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_tag_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/ibex_l2_regfile_responder_array.sv
// Flop-based storage: one write port, one combinational read port, synchronous clear.
module ibex_l2_rf_array
  import ibex_l2_rf_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 28
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [TagWidth-1:0]  waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [TagWidth-1:0]  raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [NumWords];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < NumWords)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < NumWords) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/ibex_l2_regfile_responder.sv
// L2 register backing store: one outstanding request, fixed access latency, one-cycle response.
module ibex_l2_regfile_responder
  import ibex_l2_rf_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 28,
  parameter int unsigned Latency   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  ibex_l2_regfile_responder_if.slave  bus,
  output logic                        busy_o,
  output logic [15:0]                 access_cnt_o
);

  if (Latency < 1 || Latency > 15) begin : g_latency_check
    $error("Latency must be within 1..15");
  end

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 we_q;
  logic [TagWidth-1:0]  tag_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 rsp_valid_q;
  logic [DataWidth-1:0] rsp_rdata_q;
  logic                 rsp_err_q;
  logic [15:0]          access_cnt_q;

  logic                 accept;
  logic                 commit;
  logic                 tag_ok;
  logic                 tag_writable;
  logic                 arr_we;
  logic [DataWidth-1:0] arr_rdata;
  logic [DataWidth-1:0] commit_rdata;

  assign accept = bus.req_valid_i && (state_q == IDLE);
  assign commit = (state_q == WAIT) && (cnt_q == '0);

  // Tag 0 behaves as x0: never written, always reads zero, not an error.
  always_comb begin
    tag_ok       = 32'(tag_q) < NumWords;
    tag_writable = tag_ok && (tag_q != '0);
    arr_we       = commit && we_q && tag_writable;
    commit_rdata = '0;
    if (tag_writable) begin
      commit_rdata = we_q ? wdata_q : arr_rdata;
    end
  end

  ibex_l2_rf_array #(
    .DataWidth (DataWidth),
    .NumWords  (NumWords)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (arr_we),
    .waddr_i (tag_q),
    .wdata_i (wdata_q),
    .raddr_i (tag_q),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      tag_q        <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      access_cnt_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we_i;
            tag_q   <= bus.req_tag_i;
            wdata_q <= bus.req_wdata_i;
            cnt_q   <= 4'(Latency - 1);
            state_q <= WAIT;
            if (access_cnt_q != '1) begin
              access_cnt_q <= access_cnt_q + 16'd1;
            end
          end
        end
        WAIT: begin
          if (commit) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= commit_rdata;
            rsp_err_q   <= !tag_ok;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign busy_o          = (state_q != IDLE);
  assign access_cnt_o    = access_cnt_q;

endmodule

// File: doc/ibex_l2_regfile_responder.md
# ibex_l2_regfile_responder

Backing-store responder for integer registers held outside the 8-entry L1 register file (x8–x15 stay in L1). It serves one read or write request at a time over a valid/ready handshake, applies a fixed programmable access latency, and returns a single-cycle response. It sits below the L1 register file, which acts as the initiator and stalls the ID stage while a request is outstanding.

## Interface
Parameters:
- DataWidth, 32, register data width
- NumWords, 28, storage entries, tags 0..NumWords-1
- Latency, 1, wait cycles between accept and response; legal range 1..15

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept
- req_we_i  in  1  1 = write, 0 = read
- req_tag_i  in  5  storage tag; x1–x7 map to tags 1–7, x16–x31 map to tags 12–27 (addr-4)
- req_wdata_i  in  DataWidth  write data
- rsp_valid_o  out  1  response strobe, exactly one cycle
- rsp_rdata_o  out  DataWidth  read data (for writes, the written value)
- rsp_err_o  out  1  tag out of range, qualified by rsp_valid_o
- busy_o  out  1  request in flight
- access_cnt_o  out  16  accepted-request count, saturating

## Operation
- FSM states and transitions:
  - IDLE → WAIT on accept.
  - WAIT: load cnt = Latency-1 on entry, decrement each cycle, go to RESP when cnt == 0.
  - RESP → IDLE unconditionally.
- req_ready_o = (state == IDLE). Accept = req_valid_i && req_ready_o. On accept, latch we, tag and wdata; request inputs are don't-care afterwards.
- Commit edge (WAIT→RESP):
  - Valid write to tag 1..NumWords-1: storage[tag] <= wdata; rsp_rdata_o <= wdata.
  - Read: rsp_rdata_o <= storage[tag].
  - Tag 0 (x0): read returns 0, write is dropped, rsp_err_o = 0.
  - Tag ≥ NumWords: no storage change, rsp_rdata_o = 0, rsp_err_o = 1.
- rsp_rdata_o and rsp_err_o are registered and hold their value until the next commit.
- busy_o = (state != IDLE).
- access_cnt_o increments on every accept, including errored requests, and saturates at 16'hFFFF.
- Storage is reset to zero.

## Timing
- Accept in cycle T: rsp_valid_o is high in cycle T+1+Latency only. The next accept is possible in cycle T+2+Latency. Throughput is one request per Latency+2 cycles.
- A read accepted after a write's RESP cycle observes that write. Overlap is impossible because there is a single outstanding request.
- req_valid_i held high across RESP is not accepted until the following IDLE cycle. No combinational path from req_* to req_ready_o.
- Reset values: state IDLE, req_ready_o 1 in the first cycle after reset, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, busy_o 0, access_cnt_o 0.
- Reset mid-operation: the in-flight request is abandoned, its write is not committed, and no response is issued.
- Reset has priority over accept and commit in the same cycle.

## Structure
- Package ibex_l2_rf_pkg holds:
  - the state enum {IDLE, WAIT, RESP};
  - the constants L1_LO = 8 and L1_HI = 15;
  - the function addr_to_tag(addr) (addr ≥ 16 ? addr-4 : addr), shared with the L1 register file initiator.
- One sub-module, ibex_l2_rf_array: NumWords × DataWidth flop array with synchronous reset, one write port, one read port. The FSM, counters and response registers live in the top module.

## Test plan
- Write 32'hDEAD_BEEF to tag 12, then read tag 12, with Latency=1: rsp_valid_o at T+2 for each request; read rsp_rdata_o = 32'hDEAD_BEEF; access_cnt_o = 2.
- Latency=3 with req_valid_i held high continuously: accepts in cycles 0, 5, 10; rsp_valid_o in cycles 4, 9, 14; req_ready_o low in cycles 1–4.
- Write tag 0 with 32'h1234, then read tag 0: rsp_rdata_o = 0 and rsp_err_o = 0. Read tag 30: rsp_err_o = 1, rsp_rdata_o = 0, storage unchanged.
- Write tag 20 with 32'hA5A5, assert rst_i during WAIT, then read tag 20: no response for the aborted write; read returns 0; access_cnt_o = 1 after the read.
- Preload access_cnt_o to 16'hFFFE (force or 65534 requests), then issue 3 requests: counter stops at 16'hFFFF.
- Fill all tags 1–27 with the pattern tag*32'h0101_0101, then read back all tags: every read matches and rsp_err_o stays 0 throughout.
